// File: rtl/cpu_phase_seq.sv
// Phase sequencer: derives the core's phi clock from clk and turns each phi cycle into one bus handshake.
// Define SYNC_STEP_EN to add opcode-fetch single stepping (step_mode / step / halted ports).
module cpu_phase_seq #(
  parameter int SETTLE   = 8,
  parameter int RES_HOLD = 8,
  parameter int AW       = 16,
  parameter int DW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [AW-1:0] cpu_ab,
  input  logic          cpu_rw,
  input  logic          cpu_sync,
  input  logic [DW-1:0] cpu_dbo,
  output logic          phi,
  output logic          cpu_res,
  output logic [DW-1:0] cpu_dbi,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [31:0]   cycle_cnt
`ifdef SYNC_STEP_EN
  ,
  input  logic          step_mode,
  input  logic          step,
  output logic          halted
`endif
);

  typedef enum logic [1:0] {PHI1, PHI2, BUS, HALT} state_t;

  localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] RES_LAST = 8'(RES_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] hold_q;
  logic       sync_q;
  logic       latch, bus_done, acked, halt_go;

`ifdef SYNC_STEP_EN
  logic halt_pend_q;
  assign halt_go = halt_pend_q;
  assign halted  = (state_q == HALT);
`else
  logic unused_sync;
  assign halt_go     = 1'b0;
  assign unused_sync = sync_q;
`endif

  // Both outputs decode straight from state so a reset drops them in the same clk.
  assign phi     = (state_q == PHI2) || (state_q == BUS);
  assign mem_req = (state_q == BUS) && cpu_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PHI1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 8'd1;
    latch    = 1'b0;
    bus_done = 1'b0;
    acked    = 1'b0;
    case (state_q)
      PHI1: begin
        if (cnt_q == SET_LAST) begin
          // A paused PHI1 parks on its last count, so run=1 resumes on the next clk.
          cnt_d = cnt_q;
          if (halt_go) begin
            state_d = HALT;
            cnt_d   = '0;
          end else if (run) begin
            state_d = PHI2;
            cnt_d   = '0;
          end
        end
      end
      PHI2: begin
        if (cnt_q == SET_LAST) begin
          latch   = 1'b1;
          state_d = BUS;
          cnt_d   = '0;
        end
      end
      BUS: begin
        cnt_d = '0;
        if (!cpu_res || mem_ack) begin
          bus_done = 1'b1;
          acked    = cpu_res;
          state_d  = PHI1;
        end
      end
      HALT: begin
        cnt_d = '0;
`ifdef SYNC_STEP_EN
        if (step) state_d = PHI2;
`else
        state_d = PHI1;
`endif
      end
      default: begin
        state_d = PHI1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      sync_q    <= 1'b0;
      cpu_dbi   <= '0;
      cycle_cnt <= '0;
      cpu_res   <= 1'b0;
      hold_q    <= '0;
    end else begin
      if (latch) begin
        mem_addr  <= cpu_ab;
        mem_we    <= !cpu_rw;
        mem_wdata <= cpu_dbo;
        sync_q    <= cpu_sync;
      end
      if (acked) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        if (!mem_we) cpu_dbi <= mem_rdata;
      end
      // Each BUS exit is a phi fall; release the core after RES_HOLD of them.
      if (bus_done && !cpu_res) begin
        if (hold_q == RES_LAST) cpu_res <= 1'b1;
        else                    hold_q  <= hold_q + 8'd1;
      end
    end
  end

`ifdef SYNC_STEP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              halt_pend_q <= 1'b0;
    else if (state_d == HALT)               halt_pend_q <= 1'b0;
    else if (acked && step_mode && sync_q)  halt_pend_q <= 1'b1;
  end
`endif

endmodule
